// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receiver and transmitter:
//                receiver state encoding, default bit period, frame shape
//                and the bit-counter width.
//  Contents    : uart_state_t  - 3-bit receiver state encoding
//                DEFAULT_CLKS_PER_BIT, DATA_BITS, STOP_BITS, CNT_W, BIT_IDX_W
//                half_bit()    - mid-bit count for a given bit period
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_t;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 100;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned STOP_BITS            = 1;
  localparam int unsigned CNT_W                = 16;
  localparam int unsigned BIT_IDX_W            = $clog2(DATA_BITS);

  // Count at which the start bit is re-checked; rounding down keeps the
  // sample point at or just before the true bit centre.
  function automatic logic [CNT_W-1:0] half_bit(input int unsigned clks_per_bit);
    return CNT_W'((clks_per_bit - 1) / 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Two-flop synchroniser for a single asynchronous input.
//                Both flops reset to RESET_VAL so the synchronised output
//                presents the input's idle level straight out of reset.
//  Ports       : clk   in  1  destination clock, rising edge
//                rst_n in  1  asynchronous active-low reset
//                d     in  1  asynchronous input
//                q     out 1  synchronised output, 2 clk after d changes
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // First stage may go metastable; only the second stage is consumed.
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 asynchronous serial receiver. Synchronises the line,
//                re-checks the start bit at mid-bit, samples every data bit
//                at its centre (LSB first) and checks the stop bit.
//  Ports       : clk       in  1  system clock, rising edge
//                rst_n     in  1  asynchronous active-low reset
//                rx        in  1  serial line, idle high, asynchronous
//                data_out  out 8  last good byte, held until the next one
//                valid     out 1  one-cycle pulse, data_out new this cycle
//                frame_err out 1  one-cycle pulse, stop bit sampled low
//                busy      out 1  high whenever the receiver is not idle
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [CNT_W-1:0]     HALF     = half_bit(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [DATA_BITS-1:0] shift;

  // Stop-bit verdict, captured at the stop-bit sample and turned into the
  // output pulse on the following clock.
  logic                 deliver_ok;
  logic                 deliver_err;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      deliver_ok  <= 1'b0;
      deliver_err <= 1'b0;
      data_out    <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Output stage: pulses last exactly one cycle because the verdict
      // flags are cleared below unless re-set by a new stop-bit sample,
      // which cannot happen on consecutive cycles.
      valid       <= deliver_ok;
      frame_err   <= deliver_err;
      if (deliver_ok) begin
        data_out <= shift;
      end
      deliver_ok  <= 1'b0;
      deliver_err <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              // Return to IDLE at stop-bit centre so a start bit that
              // follows immediately still has half a bit of margin.
              deliver_ok <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              deliver_err <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_IDLE: begin
          // A held-low line (break) must not decode as a stream of frames.
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
